// File: rtl/histogram_pkg.sv
// Shared FSM encodings and parameter defaults for the bin-counting histogram.
package histogram_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_COUNT_W  = 16;
  localparam int DEF_TOTAL_W  = 32;
  localparam int DEF_SATURATE = 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } hist_state_e;

endpackage

// File: rtl/histogram_dpram.sv
// Dual-port bin memory: port A carries the increment read and write-back, port B is read-only.
module histogram_dpram
  import histogram_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_we,
  input  logic [ADDR_W-1:0]  a_waddr,
  input  logic [COUNT_W-1:0] a_wdata,
  input  logic [ADDR_W-1:0]  a_raddr,
  output logic [COUNT_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0]  b_addr,
  output logic [COUNT_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [COUNT_W-1:0] mem_q [DEPTH];
  logic [COUNT_W-1:0] a_rdata_q;
  logic [COUNT_W-1:0] b_rdata_q;

  // Port A: write-back plus read-first registered read of the newly accepted bin.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_q[a_waddr] <= a_wdata;
    end
    a_rdata_q <= mem_q[a_raddr];
  end

  // Port B: the output register is cleared by reset so readValue starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata_q <= '0;
    end else begin
      b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/parametric_histogram.sv
// Streaming histogram: one sample per cycle increments its bin via a 2-stage read-modify-write
// with same-bin forwarding; a clear request drains the pipeline and sweeps every bin to zero.
module parametric_histogram
  import histogram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int TOTAL_W  = DEF_TOTAL_W,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sampleValid,
  input  logic [ADDR_W-1:0]  sampleValue,
  output logic               sampleReady,
  input  logic               readAddress_Write,
  input  logic [ADDR_W-1:0]  readAddress_WriteValue,
  output logic [ADDR_W-1:0]  readAddress,
  output logic [COUNT_W-1:0] readValue,
  input  logic               clearStart,
  output logic               clearBusy,
  output logic               saturated,
  output logic [TOTAL_W-1:0] totalCount
);

  localparam logic [COUNT_W-1:0] BIN_MAX  = '1;
  localparam logic [ADDR_W-1:0]  LAST_BIN = '1;

  hist_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic               clear_busy_q, clear_busy_d;
  logic               sample_ready_q, sample_ready_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
  logic               prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0]  prev_addr_q, prev_addr_d;
  logic [COUNT_W-1:0] prev_data_q, prev_data_d;
  logic               saturated_q, saturated_d;
  logic [TOTAL_W-1:0] total_count_q, total_count_d;
  logic [ADDR_W-1:0]  read_address_q, read_address_d;

  logic               accept_s, fwd_s, sat_evt_s;
  logic [COUNT_W-1:0] cur_s, inc_s;
  logic               ram_we_s;
  logic [ADDR_W-1:0]  ram_waddr_s;
  logic [COUNT_W-1:0] ram_wdata_s, ram_rdata_s;

  histogram_dpram #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .a_we    (ram_we_s),
    .a_waddr (ram_waddr_s),
    .a_wdata (ram_wdata_s),
    .a_raddr (sampleValue),
    .a_rdata (ram_rdata_s),
    .b_addr  (read_address_q),
    .b_rdata (readValue)
  );

  // Increment datapath; the RAM read misses the write landing in the same cycle, hence forwarding.
  always_comb begin
    accept_s = sampleValid && sample_ready_q;
    fwd_s    = s1_valid_q && prev_valid_q && (prev_addr_q == s1_addr_q);
    cur_s    = fwd_s ? prev_data_q : ram_rdata_s;
    if (cur_s == BIN_MAX) begin
      inc_s = (SATURATE != 32'sd0) ? BIN_MAX : '0;
    end else begin
      inc_s = cur_s + COUNT_W'(1);
    end
    if (SATURATE != 32'sd0) begin
      sat_evt_s = s1_valid_q && (inc_s == BIN_MAX);
    end else begin
      sat_evt_s = s1_valid_q && (cur_s == BIN_MAX);
    end
    if (clear_busy_q) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_q;
      ram_wdata_s = '0;
    end else begin
      ram_we_s    = s1_valid_q;
      ram_waddr_s = s1_addr_q;
      ram_wdata_s = inc_s;
    end
  end

  // Next-state logic for the CLEAR/RUN/DRAIN controller and bookkeeping registers.
  always_comb begin
    state_d        = state_q;
    clr_addr_d     = clr_addr_q;
    clear_busy_d   = clear_busy_q;
    sample_ready_d = sample_ready_q;
    s1_valid_d     = accept_s;
    s1_addr_d      = sampleValue;
    prev_valid_d   = s1_valid_q;
    prev_addr_d    = s1_addr_q;
    prev_data_d    = inc_s;
    saturated_d    = saturated_q | sat_evt_s;
    if (accept_s) begin
      total_count_d = total_count_q + TOTAL_W'(1);
    end else begin
      total_count_d = total_count_q;
    end
    if (readAddress_Write) begin
      read_address_d = readAddress_WriteValue;
    end else begin
      read_address_d = read_address_q;
    end
    case (state_q)
      ST_RUN: begin
        if (clearStart) begin
          state_d        = ST_DRAIN;
          sample_ready_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d       = ST_CLEAR;
          clear_busy_d  = 1'b1;
          clr_addr_d    = '0;
          total_count_d = '0;
          saturated_d   = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        // After reset the first cycle only arms the sweep, so nothing is written while held.
        if (!clear_busy_q) begin
          clear_busy_d = 1'b1;
          clr_addr_d   = '0;
        end else if (clr_addr_q == LAST_BIN) begin
          state_d        = ST_RUN;
          clear_busy_d   = 1'b0;
          sample_ready_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d        = ST_CLEAR;
        clear_busy_d   = 1'b0;
        sample_ready_d = 1'b0;
        clr_addr_d     = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      clear_busy_q   <= 1'b0;
      sample_ready_q <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= '0;
      prev_valid_q   <= 1'b0;
      prev_addr_q    <= '0;
      prev_data_q    <= '0;
      saturated_q    <= 1'b0;
      total_count_q  <= '0;
      read_address_q <= '0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      clear_busy_q   <= clear_busy_d;
      sample_ready_q <= sample_ready_d;
      s1_valid_q     <= s1_valid_d;
      s1_addr_q      <= s1_addr_d;
      prev_valid_q   <= prev_valid_d;
      prev_addr_q    <= prev_addr_d;
      prev_data_q    <= prev_data_d;
      saturated_q    <= saturated_d;
      total_count_q  <= total_count_d;
      read_address_q <= read_address_d;
    end
  end

  assign sampleReady = sample_ready_q;
  assign clearBusy   = clear_busy_q;
  assign saturated   = saturated_q;
  assign totalCount  = total_count_q;
  assign readAddress = read_address_q;

endmodule

// File: tb/tb_parametric_histogram.sv
// Directed bench: a saturating and a wrapping instance share one stimulus stream.
module tb_parametric_histogram;

  localparam int AW = 4;
  localparam int CW = 4;
  localparam int TW = 32;

  logic          clk;
  logic          reset;
  logic          sampleValid;
  logic [AW-1:0] sampleValue;
  logic          ra_wr;
  logic [AW-1:0] ra_val;
  logic          clearStart;

  logic          ready_s, ready_w, busy_s, busy_w, sat_s, sat_w;
  logic [AW-1:0] raddr_s, raddr_w;
  logic [CW-1:0] rval_s, rval_w;
  logic [TW-1:0] total_s, total_w;

  int vectors = 0;
  int miscompares = 0;

  parametric_histogram #(.ADDR_W(AW), .COUNT_W(CW), .TOTAL_W(TW), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .sampleValid(sampleValid), .sampleValue(sampleValue),
    .sampleReady(ready_s), .readAddress_Write(ra_wr), .readAddress_WriteValue(ra_val),
    .readAddress(raddr_s), .readValue(rval_s), .clearStart(clearStart),
    .clearBusy(busy_s), .saturated(sat_s), .totalCount(total_s)
  );

  parametric_histogram #(.ADDR_W(AW), .COUNT_W(CW), .TOTAL_W(TW), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .sampleValid(sampleValid), .sampleValue(sampleValue),
    .sampleReady(ready_w), .readAddress_Write(ra_wr), .readAddress_WriteValue(ra_val),
    .readAddress(raddr_w), .readValue(rval_w), .clearStart(clearStart),
    .clearBusy(busy_w), .saturated(sat_w), .totalCount(total_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] v);
    sampleValid = 1'b1;
    sampleValue = v;
    tick();
  endtask

  task automatic read_bin(input logic [AW-1:0] a, input int es, input int ew, input string tag);
    ra_wr  = 1'b1;
    ra_val = a;
    tick();
    ra_wr = 1'b0;
    tick();
    chk({tag, " sat"}, rval_s, es);
    chk({tag, " wrap"}, rval_w, ew);
  endtask

  task automatic check_all_zero(input string tag);
    for (int b = 0; b < 16; b++) begin
      read_bin(b[AW-1:0], 0, 0, $sformatf("%s bin%0d", tag, b));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " ready s"}, ready_s, 0);  chk({tag, " ready w"}, ready_w, 0);
    chk({tag, " busy s"}, busy_s, 0);    chk({tag, " busy w"}, busy_w, 0);
    chk({tag, " sat s"}, sat_s, 0);      chk({tag, " sat w"}, sat_w, 0);
    chk({tag, " total s"}, total_s, 0);  chk({tag, " total w"}, total_w, 0);
    chk({tag, " raddr s"}, raddr_s, 0);  chk({tag, " raddr w"}, raddr_w, 0);
    chk({tag, " rval s"}, rval_s, 0);    chk({tag, " rval w"}, rval_w, 0);
  endtask

  // Counts clearBusy cycles until both instances are ready again; pulses clearStart once mid-sweep.
  task automatic wait_sweep(input string tag, input int pulse_at);
    int n_s = 0;
    int n_w = 0;
    if (busy_s) n_s++;
    if (busy_w) n_w++;
    for (int i = 0; i < 40; i++) begin
      if (ready_s && ready_w) break;
      clearStart = (i == pulse_at);
      tick();
      clearStart = 1'b0;
      if (busy_s) n_s++;
      if (busy_w) n_w++;
    end
    chk({tag, " busy cycles s"}, n_s, 16);
    chk({tag, " busy cycles w"}, n_w, 16);
    chk({tag, " ready s"}, ready_s, 1);
    chk({tag, " ready w"}, ready_w, 1);
    chk({tag, " busy end s"}, busy_s, 0);
  endtask

  initial begin
    reset       = 1'b1;
    sampleValid = 1'b0;
    sampleValue = '0;
    ra_wr       = 1'b0;
    ra_val      = '0;
    clearStart  = 1'b0;

    // Power-on reset and initial sweep.
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("por");
    tick();
    tick();
    reset = 1'b1;
    wait_sweep("por sweep", -1);
    check_all_zero("por");

    // Five back-to-back samples to bin 3, with readAddress already parked on bin 3.
    read_bin(4'd3, 0, 0, "pre3");
    for (int i = 0; i < 5; i++) send(4'd3);
    sampleValid = 1'b0;
    chk("b2b total s", total_s, 5);
    chk("b2b total w", total_w, 5);
    tick(); tick(); tick();
    chk("latency s", rval_s, 5);
    chk("latency w", rval_w, 5);
    read_bin(4'd3, 5, 5, "b2b bin3");
    read_bin(4'd2, 0, 0, "b2b bin2");
    read_bin(4'd4, 0, 0, "b2b bin4");

    // Alternating 7/8.
    for (int i = 0; i < 4; i++) begin
      send(4'd7);
      send(4'd8);
    end
    sampleValid = 1'b0;
    chk("alt total", total_s, 13);
    tick(); tick();
    read_bin(4'd7, 4, 4, "alt bin7");
    read_bin(4'd8, 4, 4, "alt bin8");
    chk("pre-sat s", sat_s, 0);
    chk("pre-sat w", sat_w, 0);

    // 17 hits on bin 2: saturating holds at 15, wrapping ends at 1.
    for (int i = 0; i < 17; i++) send(4'd2);
    sampleValid = 1'b0;
    tick(); tick();
    read_bin(4'd2, 15, 1, "sat bin2");
    chk("sat flag s", sat_s, 1);
    chk("sat flag w", sat_w, 1);
    chk("sat total w", total_w, 30);

    // Clear during a stream to bin 5.
    read_bin(4'd5, 0, 0, "pre5");
    sampleValid = 1'b1;
    sampleValue = 4'd5;
    tick(); tick(); tick();
    clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    chk("drain ready s", ready_s, 0);
    chk("drain ready w", ready_w, 0);
    chk("drain total s", total_s, 34);
    tick();
    chk("drain busy s", busy_s, 0);
    chk("drain total w", total_w, 34);
    sampleValid = 1'b0;
    tick();
    chk("clr entry busy s", busy_s, 1);
    chk("last sample s", rval_s, 4);
    chk("last sample w", rval_w, 4);
    chk("clr entry total s", total_s, 0);
    chk("clr entry sat s", sat_s, 0);
    chk("clr entry sat w", sat_w, 0);
    wait_sweep("clr sweep", 5);
    chk("clr total w", total_w, 0);
    check_all_zero("clr");

    // Reset while the sweep is at bin 9.
    for (int i = 0; i < 3; i++) send(4'd15);
    sampleValid = 1'b0;
    tick();
    read_bin(4'd15, 3, 3, "pre-rst bin15");
    chk("pre-rst total", total_s, 3);
    clearStart = 1'b1;
    tick();
    clearStart = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid sweep busy s", busy_s, 1);
    chk("mid sweep rval s", rval_s, 3);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid rst");
    tick();
    tick();
    reset = 1'b1;
    wait_sweep("rst sweep", -1);
    check_all_zero("rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parametric_histogram.md
PARAMETRIC_HISTOGRAM -- requirements
Module: parametric_histogram

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning bin-index width (2^ADDR_W bins).
REQ-002 SHALL have parameter COUNT_W, default 16, meaning per-bin counter width.
REQ-003 SHALL have parameter TOTAL_W, default 32, meaning total-sample counter width.
REQ-004 SHALL have parameter SATURATE, default 1, meaning 1 = bins saturate at max, 0 = bins wrap.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sampleValid  input  1  sample offered this cycle.
REQ-008 SHALL have port sampleValue  input  ADDR_W  bin index of offered sample.
REQ-009 SHALL have port sampleReady  output  1  block accepts sample this cycle.
REQ-010 SHALL have port readAddress_Write  input  1  register-bus write strobe for read address.
REQ-011 SHALL have port readAddress_WriteValue  input  ADDR_W  new read address.
REQ-012 SHALL have port readAddress  output  ADDR_W  current read-address register.
REQ-013 SHALL have port readValue  output  COUNT_W  count of bin at readAddress.
REQ-014 SHALL have port clearStart  input  1  one-cycle request to zero all bins.
REQ-015 SHALL have port clearBusy  output  1  clear sweep in progress.
REQ-016 SHALL have port saturated  output  1  sticky: some bin hit max (SATURATE=1) or wrapped (SATURATE=0).
REQ-017 SHALL have port totalCount  output  TOTAL_W  accepted samples since last clear, wraps.

Function
REQ-018 SHALL accept a sample on a cycle where sampleValid and sampleReady are both high; one sample per cycle sustained.
REQ-019 SHALL use a three-state FSM: CLEAR (sweep), RUN (accept), DRAIN (flush pipeline before CLEAR).
REQ-020 SHALL in RUN hold sampleReady high; in DRAIN and CLEAR hold it low.
REQ-021 SHALL implement increment as pipeline: accept cycle t issues port-A read; t+1 memory data valid, incremented value written at end of t+1.
REQ-022 SHALL forward the in-flight write value when a sample at t+1 targets the same bin as the sample at t, so N back-to-back samples to one bin add exactly N.
REQ-023 SHALL make an increment visible on readValue no later than 3 cycles after acceptance when readAddress already points at that bin.
REQ-024 SHALL with SATURATE=1 hold a bin at 2^COUNT_W-1 on further hits and set saturated; with SATURATE=0 wrap to 0 and set saturated.
REQ-025 SHALL load readAddress on readAddress_Write; readValue reflects the new bin 2 cycles later via port B (read-only).
REQ-026 SHALL on clearStart in RUN go to DRAIN, wait until no increment is in flight (max 2 cycles), then CLEAR.
REQ-027 SHALL in CLEAR write 0 to bins 0..2^ADDR_W-1 in ascending order, one per cycle via port A, raise clearBusy, reset totalCount and saturated at CLEAR entry, then return to RUN.
REQ-028 SHALL ignore clearStart while in DRAIN or CLEAR.
REQ-029 SHALL increment totalCount by 1 per accepted sample, wrapping at 2^TOTAL_W.

Reset
REQ-030 SHALL on reset assertion immediately force: sampleReady 0, clearBusy 0, saturated 0, totalCount 0, readAddress 0, pipeline valids 0, readValue 0, FSM to CLEAR at bin 0.
REQ-031 SHALL after reset release run a full CLEAR sweep (2^ADDR_W cycles, clearBusy high) before first sampleReady; memory contents are not otherwise reset.
REQ-032 SHALL on reset mid-operation discard in-flight increments and restart the sweep from bin 0.

Structure
REQ-033 SHALL keep FSM state encodings and parameter defaults in shared package histogram_pkg.
REQ-034 SHALL instantiate one sub-module histogram_dpram: true dual-port RAM, 2^ADDR_W x COUNT_W, 1-cycle registered read, both ports on clk.

Verification (ADDR_W=4, COUNT_W=4 unless stated)
REQ-035 SHALL cover: reset release -> clearBusy high exactly 16 cycles, then sampleReady 1, all bins read 0.
REQ-036 SHALL cover: 5 back-to-back samples value 3 -> bin 3 reads 5, totalCount 5, other bins 0.
REQ-037 SHALL cover: alternating samples 7,8,7,8 (4 each) -> bins 7 and 8 read 4 each.
REQ-038 SHALL cover: 17 samples to bin 2 -> SATURATE=1 reads 15, saturated 1; SATURATE=0 reads 1, saturated 1.
REQ-039 SHALL cover: clearStart during stream to bin 5 -> sampleReady drops next cycle, last accepted sample still counted before sweep, all bins 0 and totalCount 0 after sweep.
REQ-040 SHALL cover: reset asserted mid-sweep at bin 9 -> outputs immediately at reset values, sweep restarts at bin 0 after release.
